// File: rtl/pipe_pkg.sv
// Shared constants and types for the inter-stage pipeline registers.
package pipe_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic wb;
        logic mem;
        logic ex;
    } pipe_ctrl_t;

    localparam int unsigned CTRL_W_DEF = $bits(pipe_ctrl_t);
    localparam int unsigned RD_W_DEF   = 5;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: holds ctrl/data/rd/inst plus valid, with load and clear enables.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned RD_W   = RD_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    input  logic [RD_W-1:0]   i_rd,
    input  logic [31:0]       i_inst,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic [RD_W-1:0]   o_rd,
    output logic [31:0]       o_inst
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    logic [RD_W-1:0]   r_rd;
    logic [31:0]       r_inst;

    // An empty slot always holds bubble values so the outputs need no masking.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
            r_rd    <= '0;
            r_inst  <= NOP_INST;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
            r_rd    <= '0;
            r_inst  <= NOP_INST;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
            r_rd    <= i_rd;
            r_inst  <= i_inst;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;
    assign o_rd    = r_rd;
    assign o_inst  = r_inst;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with flush, optional 2-entry skid buffer
// and a saturating bubble counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned RD_W   = RD_W_DEF,
    parameter int unsigned SKID   = 0,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [31:0]       in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic [31:0]       out_inst,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              w_accept;
    logic              w_retire;
    logic              w_head_load;
    logic              w_head_clear;
    logic [CTRL_W-1:0] w_head_ctrl;
    logic [DATA_W-1:0] w_head_data;
    logic [RD_W-1:0]   w_head_rd;
    logic [31:0]       w_head_inst;
    logic [CNT_W-1:0]  r_bubble_cnt;

    assign w_accept = in_valid & in_ready;
    assign w_retire = out_valid & out_ready;

    pipe_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .RD_W   (RD_W)
    ) u_head (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_load  (w_head_load),
        .i_clear (w_head_clear),
        .i_ctrl  (w_head_ctrl),
        .i_data  (w_head_data),
        .i_rd    (w_head_rd),
        .i_inst  (w_head_inst),
        .o_valid (out_valid),
        .o_ctrl  (out_ctrl),
        .o_data  (out_data),
        .o_rd    (out_rd),
        .o_inst  (out_inst)
    );

    if (SKID == 0) begin : g_single
        assign in_ready     = out_ready | ~out_valid;
        assign w_head_load  = w_accept;
        assign w_head_clear = flush | (w_retire & ~w_accept);
        assign w_head_ctrl  = in_ctrl;
        assign w_head_data  = in_data;
        assign w_head_rd    = in_rd;
        assign w_head_inst  = in_inst;
    end else begin : g_skid
        logic [1:0]        r_count;
        logic [1:0]        w_count_next;
        logic              r_in_ready;
        logic              w_skid_load;
        logic              w_skid_clear;
        logic              w_skid_valid;
        logic              w_from_skid;
        logic [CTRL_W-1:0] w_skid_ctrl;
        logic [DATA_W-1:0] w_skid_data;
        logic [RD_W-1:0]   w_skid_rd;
        logic [31:0]       w_skid_inst;

        pipe_entry #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W),
            .RD_W   (RD_W)
        ) u_skid (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .i_load  (w_skid_load),
            .i_clear (w_skid_clear),
            .i_ctrl  (in_ctrl),
            .i_data  (in_data),
            .i_rd    (in_rd),
            .i_inst  (in_inst),
            .o_valid (w_skid_valid),
            .o_ctrl  (w_skid_ctrl),
            .o_data  (w_skid_data),
            .o_rd    (w_skid_rd),
            .o_inst  (w_skid_inst)
        );

        // Head refills from the skid slot when it retires with both slots full.
        assign w_from_skid = w_skid_valid & w_retire;
        assign w_head_ctrl = w_from_skid ? w_skid_ctrl : in_ctrl;
        assign w_head_data = w_from_skid ? w_skid_data : in_data;
        assign w_head_rd   = w_from_skid ? w_skid_rd   : in_rd;
        assign w_head_inst = w_from_skid ? w_skid_inst : in_inst;

        always_comb begin
            w_count_next = r_count;
            w_head_load  = 1'b0;
            w_head_clear = 1'b0;
            w_skid_load  = 1'b0;
            w_skid_clear = 1'b0;
            if (flush) begin
                w_count_next = 2'd0;
                w_head_clear = 1'b1;
                w_skid_clear = 1'b1;
            end else begin
                case (r_count)
                    2'd0: begin
                        if (w_accept) begin
                            w_head_load  = 1'b1;
                            w_count_next = 2'd1;
                        end
                    end
                    2'd1: begin
                        if (w_accept && w_retire) begin
                            w_head_load = 1'b1;
                        end else if (w_accept) begin
                            w_skid_load  = 1'b1;
                            w_count_next = 2'd2;
                        end else if (w_retire) begin
                            w_head_clear = 1'b1;
                            w_count_next = 2'd0;
                        end
                    end
                    2'd2: begin
                        if (w_retire) begin
                            w_head_load  = 1'b1;
                            w_skid_clear = 1'b1;
                            w_count_next = 2'd1;
                        end
                    end
                    default: begin
                        w_count_next = 2'd0;
                        w_head_clear = 1'b1;
                        w_skid_clear = 1'b1;
                    end
                endcase
            end
        end

        // in_ready comes straight from a flop, precomputed from the next occupancy.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_count    <= 2'd0;
                r_in_ready <= 1'b1;
            end else begin
                r_count    <= w_count_next;
                r_in_ready <= (w_count_next != 2'd2);
            end
        end

        assign in_ready = r_in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (!out_valid && (r_bubble_cnt != {CNT_W{1'b1}})) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one single-entry instance (4-bit bubble counter) and one skid
// instance, checked against a queue-style occupancy model plus directed vector tables.
module tb_pipe_stage_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [2:0]   ctrl;
        logic [127:0] data;
        logic [4:0]   rd;
        logic [31:0]  inst;
    } ent_t;

    typedef struct packed {
        bit          fl;
        bit          vld;
        logic [31:0] inst;
        bit          ordy;
        bit          e_valid;
        logic [31:0] e_inst;
        bit          e_rdy;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        flush_v, in_valid_v, in_ready_v, out_valid_v, out_ready_v;
    logic [1:0][2:0]   in_ctrl_v, out_ctrl_v;
    logic [1:0][127:0] in_data_v, out_data_v;
    logic [1:0][4:0]   in_rd_v, out_rd_v;
    logic [1:0][31:0]  in_inst_v, out_inst_v;
    logic [3:0]        bub0;
    logic [15:0]       bub1;

    pipe_stage_reg #(
        .CTRL_W (3),
        .DATA_W (128),
        .RD_W   (5),
        .SKID   (0),
        .CNT_W  (4)
    ) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush_v[0]),
        .in_valid   (in_valid_v[0]),
        .in_ready   (in_ready_v[0]),
        .in_ctrl    (in_ctrl_v[0]),
        .in_data    (in_data_v[0]),
        .in_rd      (in_rd_v[0]),
        .in_inst    (in_inst_v[0]),
        .out_valid  (out_valid_v[0]),
        .out_ready  (out_ready_v[0]),
        .out_ctrl   (out_ctrl_v[0]),
        .out_data   (out_data_v[0]),
        .out_rd     (out_rd_v[0]),
        .out_inst   (out_inst_v[0]),
        .bubble_cnt (bub0)
    );

    pipe_stage_reg #(
        .CTRL_W (3),
        .DATA_W (128),
        .RD_W   (5),
        .SKID   (1),
        .CNT_W  (16)
    ) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush_v[1]),
        .in_valid   (in_valid_v[1]),
        .in_ready   (in_ready_v[1]),
        .in_ctrl    (in_ctrl_v[1]),
        .in_data    (in_data_v[1]),
        .in_rd      (in_rd_v[1]),
        .in_inst    (in_inst_v[1]),
        .out_valid  (out_valid_v[1]),
        .out_ready  (out_ready_v[1]),
        .out_ctrl   (out_ctrl_v[1]),
        .out_data   (out_data_v[1]),
        .out_rd     (out_rd_v[1]),
        .out_inst   (out_inst_v[1]),
        .bubble_cnt (bub1)
    );

    // Model: an ordered list of held entries (capacity 1 or 2) and a saturating bubble tally.
    ent_t        m_ent [2][2];
    int unsigned m_cnt [2];
    int unsigned m_bub [2];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] seen [$];
    vec_t        tbl [17];
    logic [31:0] exp_seen [4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic bit exp_rdy(input int d);
        if (d == 0) return out_ready_v[0] | (m_cnt[0] == 0);
        return m_cnt[1] != 2;
    endfunction

    function automatic ent_t head(input int d);
        ent_t e;
        if (m_cnt[d] > 0) return m_ent[d][0];
        e.ctrl = '0;
        e.data = '0;
        e.rd   = '0;
        e.inst = NOP;
        return e;
    endfunction

    task automatic set_in(input int d, input bit fl, input bit vld, input logic [31:0] inst,
                          input bit ordy);
        flush_v[d]     = fl;
        in_valid_v[d]  = vld;
        in_inst_v[d]   = inst;
        in_ctrl_v[d]   = inst[14:12];
        in_rd_v[d]     = inst[11:7];
        in_data_v[d]   = {inst, ~inst, inst ^ 32'h5a5a_a5a5, inst + 32'd1};
        out_ready_v[d] = ordy;
    endtask

    task automatic sample();
        ent_t h;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            h = head(d);
            chk($sformatf("s%0d_out_valid", d), 128'(out_valid_v[d]), 128'(m_cnt[d] > 0));
            chk($sformatf("s%0d_out_ctrl", d), 128'(out_ctrl_v[d]), 128'(h.ctrl));
            chk($sformatf("s%0d_out_data", d), out_data_v[d], h.data);
            chk($sformatf("s%0d_out_rd", d), 128'(out_rd_v[d]), 128'(h.rd));
            chk($sformatf("s%0d_out_inst", d), 128'(out_inst_v[d]), 128'(h.inst));
            chk($sformatf("s%0d_in_ready", d), 128'(in_ready_v[d]), 128'(exp_rdy(d)));
            chk($sformatf("s%0d_bubble_cnt", d), (d == 0) ? 128'(bub0) : 128'(bub1),
                128'(m_bub[d]));
        end
        if (out_valid_v[1] && out_ready_v[1]) seen.push_back(out_inst_v[1]);
    endtask

    task automatic advance();
        bit acc;
        bit ret;
        int unsigned bmax;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            acc  = in_valid_v[d] & exp_rdy(d);
            ret  = (m_cnt[d] > 0) && out_ready_v[d];
            bmax = (d == 0) ? 15 : 65535;
            if (m_cnt[d] == 0 && m_bub[d] < bmax) m_bub[d]++;
            if (flush_v[d]) begin
                m_cnt[d] = 0;
            end else begin
                if (ret) begin
                    m_ent[d][0] = m_ent[d][1];
                    m_cnt[d]--;
                end
                if (acc) begin
                    m_ent[d][m_cnt[d]] = '{ctrl: in_ctrl_v[d], data: in_data_v[d],
                                           rd: in_rd_v[d], inst: in_inst_v[d]};
                    m_cnt[d]++;
                end
            end
        end
        #1;
    endtask

    initial begin
        //          fl  vld inst          ordy e_vld e_inst        e_rdy
        tbl[0]  = '{0, 1, 32'h00A0_0093, 0, 0, NOP,          1};
        tbl[1]  = '{0, 1, 32'h0010_0113, 0, 1, 32'h00A0_0093, 1};
        tbl[2]  = '{0, 1, 32'h0020_0193, 0, 1, 32'h00A0_0093, 0};
        tbl[3]  = '{0, 1, 32'h0020_0193, 1, 1, 32'h00A0_0093, 0};
        tbl[4]  = '{0, 1, 32'h0020_0193, 1, 1, 32'h0010_0113, 1};
        tbl[5]  = '{0, 0, 32'h0000_0000, 1, 1, 32'h0020_0193, 1};
        tbl[6]  = '{0, 0, 32'h0000_0000, 1, 0, NOP,          1};
        tbl[7]  = '{0, 1, 32'h0040_0213, 0, 0, NOP,          1};
        tbl[8]  = '{0, 1, 32'h0050_0293, 0, 1, 32'h0040_0213, 1};
        tbl[9]  = '{1, 1, 32'h0060_0313, 0, 1, 32'h0040_0213, 0};
        tbl[10] = '{0, 0, 32'h0000_0000, 1, 0, NOP,          1};
        tbl[11] = '{0, 1, 32'h0070_0393, 0, 0, NOP,          1};
        tbl[12] = '{1, 1, 32'h0080_0413, 0, 1, 32'h0070_0393, 1};
        tbl[13] = '{0, 0, 32'h0000_0000, 0, 0, NOP,          1};
        tbl[14] = '{0, 1, 32'h0090_0493, 1, 0, NOP,          1};
        tbl[15] = '{1, 0, 32'h0000_0000, 1, 1, 32'h0090_0493, 1};
        tbl[16] = '{0, 0, 32'h0000_0000, 1, 0, NOP,          1};
        exp_seen = '{32'h00A0_0093, 32'h0010_0113, 32'h0020_0193, 32'h0090_0493};

        for (int d = 0; d < 2; d++) begin
            set_in(d, 0, 0, 32'h0, 0);
            m_cnt[d] = 0;
            m_bub[d] = 0;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state, then idle long enough to saturate the 4-bit counter (2^4 + 5 cycles).
        for (int i = 0; i < 21; i++) begin
            sample();
            advance();
        end
        sample();
        chk("s0_bubble_saturated", 128'(bub0), 128'd15);
        advance();

        // Single-entry streaming: each instruction shows one cycle after it is accepted.
        set_in(0, 0, 1, 32'h00A0_0093, 1);
        sample();
        chk("s0_stream_ready0", 128'(in_ready_v[0]), 128'd1);
        advance();
        set_in(0, 0, 1, 32'h0010_0113, 1);
        sample();
        chk("s0_stream_inst0", 128'(out_inst_v[0]), 128'h00A0_0093);
        chk("s0_stream_ready1", 128'(in_ready_v[0]), 128'd1);
        advance();
        set_in(0, 0, 0, 32'h0, 1);
        sample();
        chk("s0_stream_inst1", 128'(out_inst_v[0]), 128'h0010_0113);
        advance();
        set_in(0, 0, 0, 32'h0, 0);

        // Skid stall / flush / flush-with-retire vectors.
        seen.delete();
        for (int i = 0; i < 17; i++) begin
            set_in(1, tbl[i].fl, tbl[i].vld, tbl[i].inst, tbl[i].ordy);
            sample();
            chk($sformatf("tbl%0d_out_valid", i), 128'(out_valid_v[1]), 128'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_out_inst", i), 128'(out_inst_v[1]), 128'(tbl[i].e_inst));
            chk($sformatf("tbl%0d_in_ready", i), 128'(in_ready_v[1]), 128'(tbl[i].e_rdy));
            advance();
        end
        chk("tbl_retire_count", 128'(seen.size()), 128'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tbl_retire_order%0d", i),
                (i < seen.size()) ? 128'(seen[i]) : 128'hx, 128'(exp_seen[i]));
        end

        // Randomised traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 2; d++) begin
                set_in(d, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0, $urandom,
                       $urandom_range(0, 3) != 0);
            end
            sample();
            advance();
        end

        // Asynchronous reset while both instances hold an entry.
        set_in(0, 0, 1, 32'h00C0_0613, 0);
        set_in(1, 0, 1, 32'h00D0_0693, 0);
        sample();
        advance();
        set_in(0, 0, 0, 32'h0, 0);
        set_in(1, 0, 0, 32'h0, 0);
        sample();
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("s%0d_async_out_valid", d), 128'(out_valid_v[d]), 128'd0);
            chk($sformatf("s%0d_async_out_inst", d), 128'(out_inst_v[d]), 128'(NOP));
            chk($sformatf("s%0d_async_out_ctrl", d), 128'(out_ctrl_v[d]), 128'd0);
            m_cnt[d] = 0;
            m_bub[d] = 0;
        end
        chk("s0_async_bubble", 128'(bub0), 128'd0);
        chk("s1_async_bubble", 128'(bub1), 128'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the pipelined RISC-V core.
- One instance carries a generic control bundle, a generic data payload, rd address and instruction word, using a valid/ready handshake.
- Supports stall via out_ready backpressure, flush with bubble (NOP) insertion, and an optional 2-entry skid buffer so in_ready is registered.
- Also counts bubbles emitted downstream for the core's perf counters.

Parameters:
- CTRL_W, 3, width of the control bundle (wb/mem/ex control bits).
- DATA_W, 128, width of the concatenated data payload (e.g. alu_result, mem data, imm, pc).
- RD_W, 5, destination register address width.
- SKID, 0, 0 = single entry with combinational in_ready; 1 = 2-entry skid buffer with registered in_ready.
- CNT_W, 16, bubble counter width.

Ports:
- clk  in  1  stage clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  squash all held entries this cycle.
- in_valid  in  1  upstream stage holds a valid instruction.
- in_ready  out  1  this stage accepts this cycle.
- in_ctrl  in  CTRL_W  control bundle.
- in_data  in  DATA_W  data payload.
- in_rd  in  RD_W  destination register.
- in_inst  in  32  instruction word.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts the head.
- out_ctrl  out  CTRL_W  head control; 0 when bubble.
- out_data  out  DATA_W  head payload.
- out_rd  out  RD_W  head rd; 0 when bubble.
- out_inst  out  32  head instruction; 32'h00000013 when bubble.
- bubble_cnt  out  CNT_W  cycles with out_valid=0, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: out_valid=0, out_ctrl=0, out_data=0, out_rd=0, out_inst=32'h00000013, bubble_cnt=0. in_ready=1 from the first cycle after reset release. All entries empty.
- Reset asserted mid-operation: immediately returns every output to its reset value, regardless of clock.
- Transfers: accept = in_valid & in_ready; retire = out_valid & out_ready.
- Latency: 1 cycle from accept to out_valid when the stage is empty.
- Bubble outputs: whenever out_valid=0, out_ctrl, out_rd and out_inst must show their bubble values (0, 0, NOP). out_data is don't-care but must hold at 0.
- SKID=0:
  - in_ready = out_ready | ~out_valid (combinational).
  - Entry loads on accept, clears on retire without accept, holds otherwise (stall).
- SKID=1:
  - Occupancy count is 0..2; in_ready = (count != 2), driven from a flop.
  - Accept while the head is stalled writes the skid entry.
  - On retire, the skid entry moves to the head.
  - Simultaneous accept and retire at count=1: the head is replaced and count stays 1.
  - At count=2, in_ready=0 and no new entry is written.
  - Ordering is strictly FIFO.
- Flush:
  - Next edge forces count=0 and out_valid=0, with bubble values on the outputs.
  - Flush overrides a simultaneous accept: the input is dropped, but in_ready is still reported as computed.
  - Flush and retire in the same cycle: the retire completes downstream and the other entries are dropped.
- bubble_cnt: increments each cycle out_valid=0 and saturates at all-ones. It is not cleared by flush.
- Payload is never modified in flight. Data changes on a held entry are illegal upstream behaviour; the stage ignores them because it holds its registered copy.

Decomposition:
- Shared package pipe_pkg holds:
  - NOP_INST = 32'h00000013
  - default CTRL_W / RD_W
  - a typedef for the per-stage control bundle
- Sub-module pipe_entry: one flop slot holding ctrl/data/rd/inst/valid, with load/clear enables. It is instantiated once for SKID=0 and twice for SKID=1.
- The handshake and count logic stays in pipe_stage_reg.

Test Plan:
- Reset pulse mid-stream with rst_n low while holding a valid entry -> out_valid=0, out_inst=32'h00000013 and bubble_cnt=0 immediately (async, without waiting for a clock edge).
- SKID=0 streaming with out_ready=1 and inst 0x00A00093, 0x00100113 on consecutive cycles -> each appears on out_inst one cycle later; in_ready stays 1.
- SKID=1 stall: out_ready=0, push A then B -> count=2 and in_ready=0 on the next cycle; C is held off. Release out_ready -> A, B, C retire in order with no loss or duplication.
- Flush with count=2 and in_valid=1 -> next cycle out_valid=0, out_ctrl=0, out_rd=0, out_inst=NOP; the incoming instruction is absent from the output stream.
- Flush coincident with retire at count=1 -> the retired value is seen downstream exactly once and the stage is then empty.
- Hold out_valid=0 for 2^CNT_W+5 cycles with CNT_W=4 -> bubble_cnt saturates at 15.
